// File: rtl/vx_credit_sender_pkg.sv
// Shared types and helpers for the credit-based sender.
package VX_credit_pkg;

  // Sender flow-control states: normal sending, draining, drain-complete pulse.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits needed to hold a credit count in the range 0..size inclusive.
  function automatic int credit_w(input int size);
    return (size < 1) ? 1 : $clog2(size + 1);
  endfunction

endpackage

// File: rtl/vx_credit_sender_pipe_register.sv
// Single-stage pipeline register. Synchronous active-low reset clears the
// whole word, so a packed valid bit comes out of reset deasserted.
module VX_pipe_register #(
  parameter int DATAW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DATAW-1:0] i_data,
  output logic [DATAW-1:0] o_data
);

  logic [DATAW-1:0] r_data;

  // Capture the input word every cycle; reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= '0;
    end else begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/vx_credit_sender.sv
// Credit-based sender: forwards upstream payloads to a remote queue of depth
// SIZE, consuming one credit per accepted transfer and regaining one per
// credit_return. A flush request stops acceptance until every credit is back,
// then pulses flush_done for one cycle.
// Optional feature macro: VX_CREDIT_SENDER_OUT_REG_EN registers push/data_out
// one cycle after acceptance (the credit is still taken at acceptance).
module vx_credit_sender
  import VX_credit_pkg::*;
#(
  parameter  int DATAW = 32,
  parameter  int SIZE  = 4,
  localparam int CW    = credit_w(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             push,
  output logic [DATAW-1:0] data_out,
  input  logic             credit_return,
  input  logic             flush,
  output logic             flush_done,
  output logic [CW-1:0]    credits
);

  localparam logic [CW-1:0] FULL = CW'(SIZE);

  logic [CW-1:0] r_credits;
  state_e        r_state;
  state_e        w_state_next;
  logic          w_fire;
  logic          w_ret;
  logic          w_pending;

  // Accept only while running with a credit in hand and out of reset.
  assign ready_in = reset && (r_state == RUN) && (r_credits != '0);
  assign w_fire   = valid_in && ready_in;
  // A return with nothing outstanding is bogus; the counter saturates at SIZE.
  assign w_ret    = credit_return && (r_credits != FULL);

`ifdef VX_CREDIT_SENDER_OUT_REG_EN
  logic [DATAW:0] w_pipe_out;

  VX_pipe_register #(
    .DATAW (DATAW + 1)
  ) u_out_reg (
    .clk    (clk),
    .reset  (reset),
    .i_data ({w_fire, data_in}),
    .o_data (w_pipe_out)
  );

  assign push      = w_pipe_out[DATAW];
  assign data_out  = w_pipe_out[DATAW-1:0];
  assign w_pending = w_pipe_out[DATAW];
`else
  assign push      = w_fire;
  assign data_out  = reset ? data_in : '0;
  assign w_pending = 1'b0;
`endif

  // Credit counter: minus one per accepted transfer, plus one per valid return.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_credits <= FULL;
    end else begin
      r_credits <= r_credits - CW'(w_fire) + CW'(w_ret);
    end
  end

  // Flow-control state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush is only looked at while running.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (flush) w_state_next = DRAIN;
      DRAIN:   if ((r_credits == FULL) && !w_pending) w_state_next = DONE;
      DONE:    w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  assign flush_done = (r_state == DONE);
  assign credits    = r_credits;

  // Flag a credit returned while the counter is already full.
  a_credit_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(credit_return && (r_credits == FULL)))
    else $warning("credit_return with full credits ignored");

endmodule

// File: tb/tb_vx_credit_sender.sv
module tb_vx_credit_sender;

  localparam int DATAW = 4;
  localparam int SIZE  = 4;
`ifdef VX_CREDIT_SENDER_OUT_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b0;
  logic             valid_in = 1'b0;
  logic [DATAW-1:0] data_in = '0;
  logic             credit_return = 1'b0;
  logic             flush = 1'b0;
  logic             ready_in;
  logic             push;
  logic [DATAW-1:0] data_out;
  logic             flush_done;
  logic [2:0]       credits;

  vx_credit_sender #(.DATAW(DATAW), .SIZE(SIZE)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .ready_in      (ready_in),
    .push          (push),
    .data_out      (data_out),
    .credit_return (credit_return),
    .flush         (flush),
    .flush_done    (flush_done),
    .credits       (credits)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: available credits, flow state (0 run, 1 drain, 2 done),
  // remote queue occupancy and the payload waiting in the optional output stage.
  int               m_cred   = SIZE;
  int               m_state  = 0;
  int               m_remote = 0;
  bit               m_pend   = 1'b0;
  logic [DATAW-1:0] m_pend_data = '0;

  logic             a_ready, a_push, a_fd;
  logic [DATAW-1:0] a_data;
  logic [2:0]       a_cred;
  logic             e_ready, e_push, e_fd;
  logic [DATAW-1:0] e_data;
  logic [2:0]       e_cred;

  // One clock: sample DUT and model at the falling edge, then advance the model.
  task automatic tick();
    bit acc;
    int nxt;
    @(negedge clk);
    a_ready = ready_in; a_push = push; a_data = data_out;
    a_fd = flush_done; a_cred = credits;
    e_ready = reset && (m_state == 0) && (m_cred > 0);
    acc = valid_in && e_ready;
    if (REG) begin
      e_push = m_pend; e_data = m_pend_data;
    end else begin
      e_push = acc; e_data = data_in;
    end
    e_fd = (m_state == 2);
    e_cred = 3'(m_cred);
    @(posedge clk);
    if (!reset) begin
      m_cred = SIZE; m_state = 0; m_pend = 1'b0; m_remote = 0;
    end else begin
      if (credit_return && m_remote > 0) m_remote--;
      if (e_push) m_remote++;
      nxt = m_cred - (acc ? 1 : 0) + ((credit_return && m_cred < SIZE) ? 1 : 0);
      case (m_state)
        0: if (flush) m_state = 1;
        1: if (m_cred == SIZE && !m_pend) m_state = 2;
        default: m_state = 0;
      endcase
      m_cred = nxt;
      m_pend = REG && acc;
      m_pend_data = data_in;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; valid_in = 1'b1; data_in = 4'h9;
    tick();
    tick();
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset.ready actual=%b required=0", a_ready); end
    checks++; if (a_push !== 1'b0) begin errors++; $display("FAIL reset.push actual=%b required=0", a_push); end
    checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL reset.flush_done actual=%b required=0", a_fd); end
    checks++; if (a_cred !== 3'd4) begin errors++; $display("FAIL reset.credits actual=%0d required=4", a_cred); end
    reset = 1'b1; valid_in = 1'b0;
    tick();
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset.ready_after actual=%b required=1", a_ready); end
  endtask

  task automatic test_fill();
    logic [DATAW-1:0] vals [4];
    logic [DATAW-1:0] got [$];
    vals[0] = 4'hA; vals[1] = 4'hB; vals[2] = 4'hC; vals[3] = 4'hD;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      data_in = (i < 4) ? vals[i] : 4'hE;
      tick();
      if (a_push === 1'b1) got.push_back(a_data);
      checks++; if (a_cred !== 3'(SIZE - i)) begin errors++; $display("FAIL fill.credits[%0d] actual=%0d required=%0d", i, a_cred, SIZE - i); end
      checks++; if (a_push !== e_push) begin errors++; $display("FAIL fill.push[%0d] actual=%b required=%b", i, a_push, e_push); end
    end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL fill.ready_at_zero actual=%b required=0", a_ready); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL fill.count actual=%0d required=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== vals[i]) begin errors++; $display("FAIL fill.data[%0d] actual=%h required=%h", i, got[i], vals[i]); end
    end
  endtask

  task automatic test_stall();
    int npush = 0;
    valid_in = 1'b1; data_in = 4'hE;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (a_push !== 1'b0) begin errors++; $display("FAIL stall.push[%0d] actual=%b required=0", i, a_push); end
    end
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    tick();
    checks++; if (a_cred !== 3'd1) begin errors++; $display("FAIL stall.credits_after_return actual=%0d required=1", a_cred); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL stall.ready actual=%b required=1", a_ready); end
    if (a_push === 1'b1 && a_data === 4'hE) npush++;
    valid_in = 1'b0;
    tick();
    if (a_push === 1'b1 && a_data === 4'hE) npush++;
    checks++; if (a_cred !== 3'd0) begin errors++; $display("FAIL stall.credits_after_push actual=%0d required=0", a_cred); end
    checks++; if (npush != 1) begin errors++; $display("FAIL stall.pushes_of_e actual=%0d required=1", npush); end
  endtask

  task automatic test_simul();
    credit_return = 1'b1;
    tick(); tick();
    valid_in = 1'b1; data_in = 4'h5;
    tick();
    checks++; if (a_cred !== 3'd2) begin errors++; $display("FAIL simul.credits_before actual=%0d required=2", a_cred); end
    valid_in = 1'b0; credit_return = 1'b0;
    tick();
    checks++; if (a_cred !== 3'd2) begin errors++; $display("FAIL simul.credits_after actual=%0d required=2", a_cred); end
    checks++; if (a_cred !== e_cred) begin errors++; $display("FAIL simul.model actual=%0d required=%0d", a_cred, e_cred); end
  endtask

  task automatic test_flush();
    int nfd = 0;
    valid_in = 1'b1; data_in = 4'h3;
    tick();
    valid_in = 1'b0; flush = 1'b1;
    tick();
    checks++; if (a_cred !== 3'd1) begin errors++; $display("FAIL flush.credits_start actual=%0d required=1", a_cred); end
    flush = 1'b0; valid_in = 1'b1;
    tick();
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL flush.ready_drain actual=%b required=0", a_ready); end
    credit_return = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_ready !== 1'b0 || a_fd !== 1'b0) begin errors++; $display("FAIL flush.drain[%0d] ready=%b flush_done=%b required 0 0", i, a_ready, a_fd); end
    end
    credit_return = 1'b0; flush = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (a_fd === 1'b1) nfd++;
      if (i == 0) begin
        checks++; if (a_cred !== 3'd4) begin errors++; $display("FAIL flush.credits_full actual=%0d required=4", a_cred); end
      end
    end
    checks++; if (nfd != 1) begin errors++; $display("FAIL flush.done_pulses actual=%0d required=1", nfd); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL flush.ready_after actual=%b required=1", a_ready); end
  endtask

  task automatic test_overflow();
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    tick();
    checks++; if (a_cred !== 3'd4) begin errors++; $display("FAIL overflow.credits actual=%0d required=4", a_cred); end
  endtask

  task automatic test_reset_mid();
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 4'($urandom);
      tick();
    end
    reset = 1'b0;
    tick();
    checks++; if (a_cred !== 3'd1) begin errors++; $display("FAIL reset_mid.credits_before actual=%0d required=1", a_cred); end
    reset = 1'b1; valid_in = 1'b0;
    tick();
    checks++; if (a_cred !== 3'd4) begin errors++; $display("FAIL reset_mid.credits actual=%0d required=4", a_cred); end
    checks++; if (a_push !== 1'b0 || a_fd !== 1'b0) begin errors++; $display("FAIL reset_mid.outputs push=%b flush_done=%b required 0 0", a_push, a_fd); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_mid.ready actual=%b required=1", a_ready); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_in = 1'($urandom);
      data_in = 4'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      credit_return = (m_remote > 0) && ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 99) != 0);
      tick();
      checks++; if (a_ready !== e_ready) begin errors++; $display("FAIL random.ready[%0d] actual=%b required=%b", i, a_ready, e_ready); end
      checks++; if (a_push !== e_push) begin errors++; $display("FAIL random.push[%0d] actual=%b required=%b", i, a_push, e_push); end
      if (e_push) begin
        checks++; if (a_data !== e_data) begin errors++; $display("FAIL random.data[%0d] actual=%h required=%h", i, a_data, e_data); end
      end
      checks++; if (a_fd !== e_fd) begin errors++; $display("FAIL random.flush_done[%0d] actual=%b required=%b", i, a_fd, e_fd); end
      checks++; if (a_cred !== e_cred) begin errors++; $display("FAIL random.credits[%0d] actual=%0d required=%0d", i, a_cred, e_cred); end
    end
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; credit_return = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_simul();
    test_flush();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
